// File: rtl/hci_target_responder.sv
// -----------------------------------------------------------------------------
// hci_target_responder
//   Single-port HCI target modelling one TCDM bank. Requests are accepted on a
//   req/gnt handshake, stored into (or read from) an internal word array and
//   answered in order, one response per transaction, after LATENCY cycles.
//   A fall-through response FIFO absorbs back-pressure on r_ready_i; a credit
//   counter keeps gnt_o low whenever the FIFO could otherwise overflow.
//
//   Handshake semantics: a request transfers on a rising edge where
//   req_i & gnt_o; a response transfers on a rising edge where
//   r_valid_o & r_ready_i. While r_valid_o is high and r_ready_i is low the
//   response payload is held stable. gnt_o never looks at req_i or r_ready_i.
//
//   Optional feature macro: HCI_TARGET_RESPONDER_STALL_INJECT_EN
//     defined   -> a 16-bit LFSR randomly withholds gnt_o (~25 % of cycles)
//     undefined -> gnt_o comes from the credit rule only
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   clear_i             synchronous flush of pipeline, FIFO and credits
//   req_i / gnt_o       request valid / grant
//   add_i, wen_i        byte address, 1 = read / 0 = write
//   be_i, data_i, id_i  byte enables, write data, transaction ID
//   r_valid_o/r_ready_i response valid / accept
//   r_data_o, r_id_o    read data ('0 for writes), echoed ID
// -----------------------------------------------------------------------------
module hci_target_responder #(
   parameter int unsigned DW              = 32,
   parameter int unsigned AW              = 32,
   parameter int unsigned IW              = 8,
   parameter int unsigned DEPTH           = 1024,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned RESP_FIFO_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            req_i,
   output logic            gnt_o,
   input  logic [AW-1:0]   add_i,
   input  logic            wen_i,
   input  logic [DW/8-1:0] be_i,
   input  logic [DW-1:0]   data_i,
   input  logic [IW-1:0]   id_i,
   output logic            r_valid_o,
   input  logic            r_ready_i,
   output logic [DW-1:0]   r_data_o,
   output logic [IW-1:0]   r_id_o
);

   localparam int unsigned OFF_W = $clog2(DW/8);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(RESP_FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

   generate
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $error("hci_target_responder: LATENCY must be 1..4");
      end
      if (RESP_FIFO_DEPTH < LATENCY) begin : g_bad_fifo_depth
         $error("hci_target_responder: RESP_FIFO_DEPTH must be >= LATENCY");
      end
   endgenerate

   logic [DW-1:0]    mem [DEPTH];
   logic [IDX_W-1:0] word_idx;
   logic             hs;
   logic             accept;
   logic             credit_ok;
   logic [CNT_W-1:0] out_cnt;

   // Upper address bits wrap and sub-word bits are ignored on purpose.
   logic unused_addr;
   assign unused_addr = ^add_i;
   assign word_idx    = add_i[OFF_W +: IDX_W];

   assign credit_ok = (out_cnt < CNT_W'(RESP_FIFO_DEPTH));
   assign hs        = req_i & gnt_o;

`ifdef HCI_TARGET_RESPONDER_STALL_INJECT_EN
   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right.
   logic [15:0] lfsr;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
   assign gnt_o = credit_ok & (lfsr[1:0] != 2'b00);
`else
   assign gnt_o = credit_ok;
`endif

   // Storage array: not reset. Writes are blocked while reset is asserted.
   always_ff @(posedge clk_i) begin
      if (hs && !wen_i && !rst_i) begin
         for (int k = 0; k < DW/8; k++) begin
            if (be_i[k]) mem[word_idx][8*k +: 8] <= data_i[8*k +: 8];
         end
      end
   end

   // Response pipeline: stage 0 captures the read data on the handshake edge.
   logic          pipe_valid [LATENCY];
   logic [DW-1:0] pipe_data  [LATENCY];
   logic [IW-1:0] pipe_id    [LATENCY];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_data[i]  <= '0;
            pipe_id[i]    <= '0;
         end
      end else begin
         pipe_valid[0] <= hs & ~clear_i;
         pipe_data[0]  <= wen_i ? mem[word_idx] : '0;
         pipe_id[0]    <= id_i;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1] & ~clear_i;
            pipe_data[i]  <= pipe_data[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   // Fall-through response FIFO. The last pipeline stage bypasses the FIFO
   // only when the FIFO is empty, which keeps responses in order.
   logic [DW-1:0]    fifo_data [RESP_FIFO_DEPTH];
   logic [IW-1:0]    fifo_id   [RESP_FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty, last_valid, push, pop;
   logic [DW-1:0]    head_data;
   logic [IW-1:0]    head_id;

   assign last_valid = pipe_valid[LATENCY-1];
   assign fifo_empty = (fifo_cnt == '0);
   assign r_valid_o  = ~fifo_empty | last_valid;
   assign head_data  = fifo_empty ? pipe_data[LATENCY-1] : fifo_data[rd_ptr];
   assign head_id    = fifo_empty ? pipe_id[LATENCY-1]   : fifo_id[rd_ptr];
   assign r_data_o   = r_valid_o ? head_data : '0;
   assign r_id_o     = r_valid_o ? head_id   : '0;
   assign accept     = r_valid_o & r_ready_i;
   assign pop        = accept & ~fifo_empty;
   assign push       = last_valid & ~(fifo_empty & accept);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
         fifo_id[wr_ptr]   <= pipe_id[LATENCY-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (clear_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Credits count every transaction between handshake and response accept,
   // so pipeline plus FIFO contents can never exceed RESP_FIFO_DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        out_cnt <= '0;
      else if (clear_i) out_cnt <= '0;
      else              out_cnt <= out_cnt + CNT_W'(hs) - CNT_W'(accept);
   end

endmodule

// File: tb/tb_hci_target_responder.sv
// -----------------------------------------------------------------------------
// tb_hci_target_responder
//   Self-checking bench for hci_target_responder (LATENCY=2, FIFO depth 4).
//   A transaction-level model keeps the expected responses as a queue of
//   {ready cycle, data, id}; outputs are compared to it every cycle. Directed
//   scenarios pin literal values, then a randomized phase stresses the design.
// -----------------------------------------------------------------------------
module tb_hci_target_responder;

   localparam int unsigned LAT = 2;
   localparam int unsigned FD  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] add = '0;
   logic        wen = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic [7:0]  id = '0;
   logic        r_valid;
   logic        r_ready = 1'b1;
   logic [31:0] r_data;
   logic [7:0]  r_id;

   hci_target_responder #(
      .DW(32), .AW(32), .IW(8), .DEPTH(1024), .LATENCY(LAT), .RESP_FIFO_DEPTH(FD)
   ) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req), .gnt_o(gnt),
      .add_i(add), .wen_i(wen), .be_i(be), .data_i(wdata), .id_i(id),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_id_o(r_id)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   typedef struct {
      int unsigned ready;
      logic [31:0] data;
      logic [7:0]  id;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] mdl_mem [1024];
   logic [31:0] acc_data_q[$];
   logic [7:0]  acc_id_q[$];
   int unsigned cyc = 0;
   int unsigned hs_total = 0;
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   bit          rand_phase = 1'b0;
   int unsigned credit_cycles = 0;
   int unsigned stall_cycles = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Compare process: checks outputs, then commits what the next edge does.
   always @(negedge clk) begin
      logic        exp_v;
      logic        hs;
      logic [9:0]  idx;
      logic [31:0] rd;
      if (rst) begin
         exp_q.delete();
      end else begin
         exp_v = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
         check("r_valid", r_valid, exp_v);
`ifdef HCI_TARGET_RESPONDER_STALL_INJECT_EN
         check("gnt_credit", gnt & (exp_q.size() >= FD), 1'b0);
`else
         check("gnt", gnt, exp_q.size() < FD);
`endif
         if (rand_phase && exp_q.size() < FD) begin
            credit_cycles++;
            if (!gnt) stall_cycles++;
         end
         if (exp_v) begin
            check("r_id", r_id, exp_q[0].id);
            check("r_data", r_data, exp_q[0].data);
         end
         if (r_valid && r_ready) begin
            acc_data_q.push_back(r_data);
            acc_id_q.push_back(r_id);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (clear) exp_q.delete();
         hs = req & gnt;
         if (hs) begin
            hs_total++;
            idx = add[11:2];
            rd  = wen ? mdl_mem[idx] : 32'h0;
            if (!wen) begin
               for (int k = 0; k < 4; k++)
                  if (be[k]) mdl_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            end
            if (!clear) exp_q.push_back('{cyc + LAT, rd, id});
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [7:0] i);
      bit got = 1'b0;
      req = 1'b1; wen = w; add = a; wdata = d; be = b; id = i;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         got = gnt;
         @(posedge clk); #1;
      end
      if (!got) check("issue_grant_timeout", got, 1'b1);
      req = 1'b0;
   endtask

   task automatic wait_log(input int unsigned n);
      for (int c = 0; c < 200 && acc_id_q.size() < n; c++) begin
         @(posedge clk); #1;
      end
      if (acc_id_q.size() < n) check("resp_timeout", acc_id_q.size(), n);
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int unsigned base;
      int unsigned grants;
      int unsigned hs_start;
      bit          g;

      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_r_valid", r_valid, 1'b0);
      check("reset_r_data", r_data, 32'h0);
      check("reset_r_id", r_id, 8'h0);
      check("reset_gnt", gnt, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(2);

      // 1: write then read back, write response carries zero data
      base = acc_id_q.size();
      issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3);
      issue(1'b1, 32'h10, 32'h0, 4'h0, 8'd4);
      wait_log(base + 2);
      check("t1_wr_id", acc_id_q[base], 8'd3);
      check("t1_wr_data", acc_data_q[base], 32'h0);
      check("t1_rd_id", acc_id_q[base+1], 8'd4);
      check("t1_rd_data", acc_data_q[base+1], 32'hDEADBEEF);

      // 2: partial byte-enable write
      base = acc_id_q.size();
      issue(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 8'd5);
      issue(1'b0, 32'h20, 32'h00000000, 4'b0101, 8'd6);
      issue(1'b1, 32'h20, 32'h0, 4'h0, 8'd7);
      wait_log(base + 3);
      check("t2_rd_data", acc_data_q[base+2], 32'hFF00FF00);

      // 4: address wrap to word 0
      base = acc_id_q.size();
      issue(1'b0, 32'h1000, 32'h12345678, 4'hF, 8'd8);
      issue(1'b1, 32'h0, 32'h0, 4'h0, 8'd9);
      wait_log(base + 2);
      check("t4_wrap_data", acc_data_q[base+1], 32'h12345678);

      // 3: back-pressure, exactly FD grants, then in-order drain
      base = acc_id_q.size();
      r_ready = 1'b0;
      req = 1'b1; wen = 1'b1; add = 32'h10; id = 8'd10; grants = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         g = gnt;
         if (g) grants++;
         @(posedge clk); #1;
         id = 8'(10 + grants);
      end
      req = 1'b0;
      check("t3_grants", grants, FD);
      r_ready = 1'b1;
      wait_log(base + 4);
      for (int k = 0; k < 4; k++) check("t3_order_id", acc_id_q[base+k], 8'(10 + k));

      // 5: clear with responses in flight
      cycles(2);
      r_ready = 1'b0;
      issue(1'b1, 32'h20, 32'h0, 4'h0, 8'd20);
      issue(1'b1, 32'h20, 32'h0, 4'h0, 8'd21);
      issue(1'b1, 32'h20, 32'h0, 4'h0, 8'd22);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      check("t5_valid_after_clear", r_valid, 1'b0);
`ifndef HCI_TARGET_RESPONDER_STALL_INJECT_EN
      check("t5_gnt_after_clear", gnt, 1'b1);
`endif
      @(posedge clk); #1;
      r_ready = 1'b1;
      base = acc_id_q.size();
      cycles(10);
      check("t5_no_stale", acc_id_q.size(), base);
      issue(1'b1, 32'h0, 32'h0, 4'h0, 8'd23);
      wait_log(base + 1);
      check("t5_read_after_clear", acc_data_q[base], 32'h12345678);

      // 6: randomized traffic over 16 words with random upper address bits
      for (int w = 0; w < 16; w++) issue(1'b0, 32'(w) << 2, $urandom(), 4'hF, 8'(w));
      hs_start = hs_total;
      rand_phase = 1'b1;
      for (int c = 0; c < 20000 && hs_total < hs_start + 1000; c++) begin
         req     = ($urandom_range(0, 99) < 70);
         wen     = $urandom_range(0, 1);
         add     = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
         wdata   = $urandom();
         be      = 4'($urandom_range(0, 15));
         id      = 8'($urandom_range(0, 255));
         r_ready = ($urandom_range(0, 99) < 70);
         clear   = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      rand_phase = 1'b0;
      req = 1'b0; clear = 1'b0; r_ready = 1'b1;
      if (hs_total < hs_start + 1000) check("rand_handshakes", hs_total - hs_start, 1000);
`ifdef HCI_TARGET_RESPONDER_STALL_INJECT_EN
      check("stall_ratio_in_band",
            (stall_cycles * 100 >= credit_cycles * 15) && (stall_cycles * 100 <= credit_cycles * 35),
            1'b1);
`endif

      // drain
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin @(posedge clk); #1; end
      check("drain_empty", exp_q.size(), 0);
      cycles(3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
